// File: rtl/dram_arbiter_pkg.sv
// rtl/dram_arbiter_pkg.sv - shared memory bus types, arbiter enums and defaults
package dram_arbiter_pkg;

  localparam int ARB_TIMEOUT_DEFAULT = 1024;
  localparam int ARB_CNT_W_DEFAULT   = 10;

  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [1:0]  mem_mode;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } mem_in_type;

  typedef struct packed {
    logic        mem_ready;
    logic        mem_error;
    logic [31:0] mem_rdata;
  } mem_out_type;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
  typedef enum logic {IMEM, DMEM} arb_req_t;

  function automatic arb_req_t other_req(input arb_req_t r);
    return (r == IMEM) ? DMEM : IMEM;
  endfunction

endpackage

// File: rtl/dram_arbiter_slot.sv
// rtl/dram_arbiter_slot.sv - one pending-request holding slot per requester
module dram_arbiter_slot
  import dram_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  mem_in_type req_in,
  input  logic       clr,
  output logic       pend,
  output mem_in_type req
);

  // capture when free or freed this cycle (a new request beats the clear); else honour clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend <= 1'b0;
      req  <= '0;
    end else if (req_in.mem_valid && (!pend || clr)) begin
      pend <= 1'b1;
      req  <= req_in;
    end else if (clr) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - round-robin sharing of the DRAM port between fetch and data
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
  parameter int CNT_W   = ARB_CNT_W_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  dram_in,
  input  mem_out_type dram_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TMO_EN   = (TIMEOUT != 0);

  arb_state_t       state, state_next;
  arb_req_t         grant, last_grant, pick;
  logic [CNT_W-1:0] cnt;
  logic             pend_i, pend_d, clr_i, clr_d, load, done;
  mem_in_type       slot_i, slot_d;
  mem_out_type      rsp;

  dram_arbiter_slot u_slot_i (
    .clock  (clock),
    .reset  (reset),
    .req_in (imem_in),
    .clr    (clr_i),
    .pend   (pend_i),
    .req    (slot_i)
  );

  dram_arbiter_slot u_slot_d (
    .clock  (clock),
    .reset  (reset),
    .req_in (dmem_in),
    .clr    (clr_d),
    .pend   (pend_d),
    .req    (slot_d)
  );

  assign clr_i = done && (grant == IMEM);
  assign clr_d = done && (grant == DMEM);

  // round-robin pick: on a tie the requester not served last goes next
  always_comb begin
    if (pend_i && pend_d) pick = other_req(last_grant);
    else if (pend_i)      pick = IMEM;
    else                  pick = DMEM;
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next state plus the response word handed to the granted requester
  always_comb begin
    state_next = state;
    load       = 1'b0;
    done       = 1'b0;
    rsp        = '0;
    case (state)
      IDLE: begin
        if (pend_i || pend_d) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        if (dram_out.mem_ready) begin
          done           = 1'b1;
          rsp.mem_ready  = 1'b1;
          rsp.mem_error  = dram_out.mem_error;
          rsp.mem_rdata  = dram_out.mem_rdata;
          state_next     = IDLE;
        end else if (TMO_EN && (cnt == CNT_LAST)) begin
          done           = 1'b1;
          rsp.mem_ready  = 1'b1;
          rsp.mem_error  = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // downstream request register, grant bookkeeping, timeout counter and response outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant      <= IMEM;
      last_grant <= DMEM;
      cnt        <= '0;
      dram_in    <= '0;
      imem_out   <= '0;
      dmem_out   <= '0;
    end else begin
      imem_out <= (grant == IMEM) ? rsp : '0;
      dmem_out <= (grant == DMEM) ? rsp : '0;
      if (load) begin
        grant             <= pick;
        dram_in           <= (pick == IMEM) ? slot_i : slot_d;
        dram_in.mem_valid <= 1'b1;
        dram_in.mem_instr <= (pick == IMEM);
      end
      if (state == ISSUE) begin
        dram_in.mem_valid <= 1'b0;
        cnt               <= '0;
      end else if (state == WAIT) begin
        if (done) last_grant <= grant;
        else      cnt        <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - scoreboard bench for dram_arbiter
module tb_dram_arbiter;
  import dram_arbiter_pkg::*;

  localparam int TMO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  mem_in_type  imem_in = '0;
  mem_in_type  dmem_in = '0;
  mem_in_type  dram_in;
  mem_out_type imem_out, dmem_out;
  mem_out_type dram_out = '0;

  dram_arbiter #(.TIMEOUT(TMO), .CNT_W(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .imem_in  (imem_in),
    .imem_out (imem_out),
    .dmem_in  (dmem_in),
    .dmem_out (dmem_out),
    .dram_in  (dram_in),
    .dram_out (dram_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        instr;
    logic [1:0]  mode;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          at;
  } iss_t;

  typedef struct {
    logic        is_d;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  iss_t exp_iss[$];
  rsp_t exp_rsp[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          lat       = 5;
  bit          mute      = 1'b0;
  bit          stray_req = 1'b0;
  int          due       = -1;
  int          rdy_cyc   = -1;
  int          iss_cyc   = -1;
  logic [31:0] cur_addr  = '0;
  logic        prev_valid = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return 32'hDEADBEEF ^ (a - 32'h100);
  endfunction

  // DRAM model: answers a fixed latency after each issue, unless muted; can inject a stray ready
  always @(posedge clock) begin
    cyc = cyc + 1;
    #1;
    dram_out = '0;
    if ((due == cyc && !mute) || stray_req) begin
      dram_out.mem_ready = 1'b1;
      dram_out.mem_rdata = rdata_of(cur_addr);
      if (!stray_req) rdy_cyc = cyc;
      stray_req = 1'b0;
    end
  end

  iss_t        mon_e;
  rsp_t        mon_r;
  mem_out_type mon_g, mon_o;

  // monitor: compares issues and responses against the scoreboard away from the active edge
  always @(negedge clock) begin
    if (reset) begin
      if (dram_in.mem_valid) begin
        check_val("valid_gap", prev_valid, 1'b0);
        check_val("issue_expected", exp_iss.size() != 0, 1'b1);
        if (exp_iss.size() != 0) begin
          mon_e = exp_iss.pop_front();
          check_val("iss_instr", dram_in.mem_instr, mon_e.instr);
          check_val("iss_addr",  dram_in.mem_addr,  mon_e.addr);
          check_val("iss_wdata", dram_in.mem_wdata, mon_e.wdata);
          check_val("iss_wstrb", dram_in.mem_wstrb, mon_e.wstrb);
          check_val("iss_mode",  dram_in.mem_mode,  mon_e.mode);
          if (mon_e.at >= 0) check_val("iss_latency", cyc, mon_e.at);
        end
        iss_cyc  = cyc;
        cur_addr = dram_in.mem_addr;
        due      = cyc + lat;
      end
      prev_valid = dram_in.mem_valid;
      if (imem_out.mem_ready || dmem_out.mem_ready) begin
        check_val("rsp_expected", exp_rsp.size() != 0, 1'b1);
        if (exp_rsp.size() != 0) begin
          mon_r = exp_rsp.pop_front();
          mon_g = mon_r.is_d ? dmem_out : imem_out;
          mon_o = mon_r.is_d ? imem_out : dmem_out;
          check_val("rsp_port", {imem_out.mem_ready, dmem_out.mem_ready}, mon_r.is_d ? 2'b01 : 2'b10);
          check_val("rsp_rdata", mon_g.mem_rdata, mon_r.rdata);
          check_val("rsp_error", mon_g.mem_error, mon_r.err);
          check_val("rsp_other", mon_o, '0);
          if (mon_r.err) check_val("rsp_tmo_cycle", cyc, iss_cyc + TMO + 1);
          else           check_val("rsp_cycle", cyc, rdy_cyc + 1);
        end
      end else begin
        check_val("idle_out", {imem_out, dmem_out}, '0);
      end
    end
  end

  task automatic drive_req(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [1:0] mode);
    mem_in_type m;
    m           = '0;
    m.mem_valid = 1'b1;
    m.mem_instr = is_d;
    m.mem_addr  = addr;
    m.mem_wdata = wdata;
    m.mem_wstrb = wstrb;
    m.mem_mode  = mode;
    if (is_d) dmem_in = m;
    else      imem_in = m;
  endtask

  task automatic setup_req(input bit is_d, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [1:0] mode, input int at, input bit err);
    iss_t e;
    rsp_t r;
    drive_req(is_d, addr, wdata, wstrb, mode);
    e.instr = !is_d;
    e.addr  = addr;
    e.wdata = wdata;
    e.wstrb = wstrb;
    e.mode  = mode;
    e.at    = at;
    exp_iss.push_back(e);
    r.is_d  = is_d;
    r.err   = err;
    r.rdata = err ? 32'h0 : rdata_of(addr);
    exp_rsp.push_back(r);
  endtask

  task automatic clear_in();
    @(posedge clock);
    #1;
    imem_in = '0;
    dmem_in = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_iss.size() != 0 || exp_rsp.size() != 0) && n < budget) begin
      @(posedge clock);
      n++;
    end
    check_val("drain", exp_iss.size() + exp_rsp.size(), 0);
    repeat (3) @(posedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_val("rst_dram_in", dram_in, '0);
    check_val("rst_outs", {imem_out, dmem_out}, '0);
    reset = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: run did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int t;
    repeat (3) @(negedge clock);
    check_val("rst_dram_in", dram_in, '0);
    check_val("rst_imem_out", imem_out, '0);
    check_val("rst_dmem_out", dmem_out, '0);
    reset = 1'b1;

    // 1: single fetch
    @(posedge clock); #1; t = cyc;
    setup_req(1'b0, 32'h100, 32'h0, 4'h0, 2'd1, t + 2, 1'b0);
    clear_in();
    wait_drain(100);

    // 2: simultaneous fetch and data after reset, fetch first
    do_reset();
    @(posedge clock); #1; t = cyc;
    setup_req(1'b0, 32'h200, 32'h0, 4'h0, 2'd0, t + 2, 1'b0);
    setup_req(1'b1, 32'h204, 32'h12345678, 4'hF, 2'd2, -1, 1'b0);
    clear_in();
    wait_drain(100);

    // 3: repeated ties alternate, then a lone fetch makes data win the next tie
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1; t = cyc;
      setup_req(1'b0, 32'h2000 + 32'(k * 16), 32'h0, 4'h0, 2'(k), t + 2, 1'b0);
      setup_req(1'b1, 32'h3000 + 32'(k * 16), 32'hA0 + 32'(k), 4'h3, 2'(k), -1, 1'b0);
      clear_in();
      wait_drain(100);
    end
    @(posedge clock); #1; t = cyc;
    setup_req(1'b0, 32'h4000, 32'h0, 4'h0, 2'd0, t + 2, 1'b0);
    clear_in();
    wait_drain(100);
    @(posedge clock); #1; t = cyc;
    setup_req(1'b1, 32'h5004, 32'h55AA55AA, 4'h1, 2'd3, t + 2, 1'b0);
    setup_req(1'b0, 32'h5000, 32'h0, 4'h0, 2'd1, -1, 1'b0);
    clear_in();
    wait_drain(100);

    // 4: silent DRAM times out, a stray ready is dropped, next request is normal
    mute = 1'b1;
    @(posedge clock); #1; t = cyc;
    setup_req(1'b1, 32'h600, 32'hCAFEF00D, 4'hC, 2'd2, t + 2, 1'b1);
    clear_in();
    wait_drain(100);
    mute = 1'b0;
    @(negedge clock);
    stray_req = 1'b1;
    repeat (4) @(posedge clock);
    #1; t = cyc;
    setup_req(1'b1, 32'h640, 32'h0BADF00D, 4'h5, 2'd1, t + 2, 1'b0);
    clear_in();
    wait_drain(100);

    // 5: asynchronous reset while waiting, late response dropped, fresh request completes
    lat = 12;
    @(posedge clock); #1; t = cyc;
    setup_req(1'b0, 32'h500, 32'h0, 4'h0, 2'd0, t + 2, 1'b0);
    clear_in();
    repeat (3) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_val("async_rst_dram_in", dram_in, '0);
    check_val("async_rst_imem_out", imem_out, '0);
    check_val("async_rst_dmem_out", dmem_out, '0);
    exp_rsp.delete();
    check_val("async_rst_iss_done", exp_iss.size(), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (14) @(posedge clock);
    lat = 5;
    #1; t = cyc;
    setup_req(1'b0, 32'h540, 32'h0, 4'h0, 2'd3, t + 2, 1'b0);
    clear_in();
    wait_drain(100);

    // 6: second data pulse while data slot is pending is ignored
    @(posedge clock); #1; t = cyc;
    setup_req(1'b1, 32'h700, 32'h11112222, 4'h6, 2'd1, t + 2, 1'b0);
    @(posedge clock); #1;
    drive_req(1'b1, 32'h7F0, 32'h33334444, 4'h9, 2'd2);
    clear_in();
    wait_drain(100);
    repeat (20) @(posedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
